// File: rtl/hilo_md_unit_pkg.sv
// Shared HILOType encodings and default sequencing latencies for the HI/LO multiply/divide unit.
// The HILOType codes must stay identical to the decoder's definitions.
package hilo_md_unit_pkg;

    localparam logic [3:0] HILO_mult  = 4'd0;
    localparam logic [3:0] HILO_multu = 4'd1;
    localparam logic [3:0] HILO_div   = 4'd2;
    localparam logic [3:0] HILO_divu  = 4'd3;
    localparam logic [3:0] HILO_mfhi  = 4'd4;
    localparam logic [3:0] HILO_mflo  = 4'd5;
    localparam logic [3:0] HILO_mthi  = 4'd6;
    localparam logic [3:0] HILO_mtlo  = 4'd7;
    localparam logic [3:0] HILO_none  = 4'b1111;

    localparam int unsigned MULT_CYCLES_DEFAULT = 5;
    localparam int unsigned DIV_CYCLES_DEFAULT  = 10;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } md_state_e;

endpackage

// File: rtl/hilo_md_unit_md_compute.sv
// Combinational 32x32 multiply/divide producing a 64-bit HI/LO pair.
// div_zero flags a div/divu with a zero divisor so the caller can suppress the commit.
module md_compute
    import hilo_md_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        b_zero;
    logic        sdiv_ovf;
    logic [31:0] safe_bs;
    logic [31:0] safe_bu;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] quo_u;
    logic [31:0] rem_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'b0, a} * {32'b0, b};

    assign b_zero   = (b == 32'd0);
    assign sdiv_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Substitute a divisor of 1 in the undefined cases; their results are overridden below.
    assign safe_bs = (b_zero || sdiv_ovf) ? 32'd1 : b;
    assign safe_bu = b_zero ? 32'd1 : b;

    assign quo_s = $signed(a) / $signed(safe_bs);
    assign rem_s = $signed(a) % $signed(safe_bs);
    assign quo_u = a / safe_bu;
    assign rem_u = a % safe_bu;

    assign div_zero = b_zero && ((op == HILO_div) || (op == HILO_divu));

    always_comb begin
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            HILO_mult: begin
                hi = prod_s[63:32];
                lo = prod_s[31:0];
            end
            HILO_multu: begin
                hi = prod_u[63:32];
                lo = prod_u[31:0];
            end
            HILO_div: begin
                if (sdiv_ovf) begin
                    hi = 32'd0;
                    lo = 32'h8000_0000;
                end else begin
                    hi = rem_s;
                    lo = quo_s;
                end
            end
            HILO_divu: begin
                hi = rem_u;
                lo = quo_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hilo_md_unit.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-latency busy sequencing and the
// D-stage stall request that holds later HI/LO users back while an operation is in flight.
module hilo_md_unit
    import hilo_md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [3:0]  hilo_type,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_hilo_use,
    output logic        start,
    output logic        busy,
    output logic [31:0] hilo_out,
    output logic        stall_hilo
);

    localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
    localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_skip_q, pend_skip_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        calc_div_zero;
    logic        is_mult;

    md_compute u_md_compute (
        .op       (hilo_type),
        .a        (rs_val),
        .b        (rt_val),
        .hi       (calc_hi),
        .lo       (calc_lo),
        .div_zero (calc_div_zero)
    );

    assign busy       = (state_q == StRun);
    assign start      = e_valid && (hilo_type <= HILO_divu) && !busy;
    assign stall_hilo = d_hilo_use && (start || busy);
    assign is_mult    = (hilo_type == HILO_mult) || (hilo_type == HILO_multu);

    always_comb begin
        hilo_out = 32'd0;
        if (hilo_type == HILO_mfhi) begin
            hilo_out = hi_q;
        end else if (hilo_type == HILO_mflo) begin
            hilo_out = lo_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_hi_d   = pend_hi_q;
        pend_lo_d   = pend_lo_q;
        pend_skip_d = pend_skip_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StRun;
                    cnt_d       = is_mult ? MultLoad : DivLoad;
                    pend_hi_d   = calc_hi;
                    pend_lo_d   = calc_lo;
                    pend_skip_d = calc_div_zero;
                end else if (e_valid && (hilo_type == HILO_mthi)) begin
                    hi_d = rs_val;
                end else if (e_valid && (hilo_type == HILO_mtlo)) begin
                    lo_d = rs_val;
                end
            end
            StRun: begin
                // mt* and md requests arriving here are dropped; the stall keeps them out.
                if (cnt_q == 4'd1) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                    if (!pend_skip_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            pend_hi_q   <= 32'd0;
            pend_lo_q   <= 32'd0;
            pend_skip_q <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_hi_q   <= pend_hi_d;
            pend_lo_q   <= pend_lo_d;
            pend_skip_q <= pend_skip_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

endmodule

// File: tb/tb_hilo_md_unit.sv
// Directed bench for hilo_md_unit: expected HI/LO pairs are queued at start and
// checked via mfhi/mflo once busy drops.
module tb_hilo_md_unit;
    import hilo_md_unit_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    logic        clk;
    logic        reset;
    logic        e_valid;
    logic [3:0]  hilo_type;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_hilo_use;
    logic        start;
    logic        busy;
    logic [31:0] hilo_out;
    logic        stall_hilo;

    int   total;
    int   bad;
    int   n;
    int   s;
    bit   done;
    res_t sb[$];

    hilo_md_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .e_valid    (e_valid),
        .hilo_type  (hilo_type),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .d_hilo_use (d_hilo_use),
        .start      (start),
        .busy       (busy),
        .hilo_out   (hilo_out),
        .stall_hilo (stall_hilo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        e_valid   = 1'b0;
        hilo_type = HILO_none;
        rs_val    = 32'd0;
        rt_val    = 32'd0;
    endtask

    task automatic start_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo);
        res_t r;
        @(negedge clk);
        e_valid   = 1'b1;
        hilo_type = op;
        rs_val    = a;
        rt_val    = b;
        #1;
        chk("start_pulse", 32'(start), 32'd1);
        r.hi = ehi;
        r.lo = elo;
        sb.push_back(r);
    endtask

    task automatic wait_done(input string tag, input int exp_cycles);
        int cnt;
        cnt = 0;
        @(negedge clk);
        idle();
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk(tag, 32'(cnt), 32'(exp_cycles));
    endtask

    task automatic check_reg(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        hilo_type = HILO_mfhi;
        #1;
        chk({tag, "_hi"}, hilo_out, ehi);
        hilo_type = HILO_mflo;
        #1;
        chk({tag, "_lo"}, hilo_out, elo);
        hilo_type = HILO_none;
    endtask

    task automatic check_res(input string tag);
        res_t r;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            r = sb.pop_front();
            check_reg(tag, r.hi, r.lo);
        end
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] val, input logic ev);
        @(negedge clk);
        e_valid   = ev;
        hilo_type = op;
        rs_val    = val;
        @(negedge clk);
        idle();
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        d_hilo_use = 1'b0;
        idle();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        check_reg("reset", 32'd0, 32'd0);

        start_md(HILO_multu, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        wait_done("multu_cycles", 5);
        check_res("multu");

        start_md(HILO_mult, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        wait_done("mult_cycles", 5);
        check_res("mult");

        start_md(HILO_div, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_done("div_cycles", 10);
        check_res("div_neg");

        start_md(HILO_div, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        wait_done("div2_cycles", 10);
        check_res("div_negdivisor");

        mt(HILO_mthi, 32'h11, 1'b1);
        mt(HILO_mtlo, 32'h22, 1'b1);
        check_reg("mt_setup", 32'h11, 32'h22);
        start_md(HILO_divu, 32'd7, 32'd0, 32'h11, 32'h22);
        wait_done("divu0_cycles", 10);
        check_res("divu_zero");

        start_md(HILO_div, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        wait_done("ovf_cycles", 10);
        check_res("div_ovf");

        start_md(HILO_divu, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        wait_done("divu_big_cycles", 10);
        check_res("divu_big");

        start_md(HILO_divu, 32'd100, 32'd7, 32'd2, 32'd14);
        wait_done("divu_cycles", 10);
        check_res("divu");

        // Stall window with a second mult offered during busy.
        @(negedge clk);
        d_hilo_use = 1'b1;
        e_valid    = 1'b1;
        hilo_type  = HILO_mult;
        rs_val     = 32'd3;
        rt_val     = 32'd4;
        #1;
        chk("stall_start", 32'(start), 32'd1);
        sb.push_back('{hi: 32'd0, lo: 32'd12});
        s    = (stall_hilo === 1'b1) ? 1 : 0;
        n    = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            idle();
            if (n == 1) begin
                e_valid   = 1'b1;
                hilo_type = HILO_mult;
                rs_val    = 32'd100;
                rt_val    = 32'd100;
            end
            #1;
            if (n == 1) chk("start_while_busy", 32'(start), 32'd0);
            if (stall_hilo === 1'b1) s++;
            else done = 1'b1;
            n++;
        end
        chk("stall_cycles", 32'(s), 32'd6);
        chk("busy_after_stall", 32'(busy), 32'd0);
        d_hilo_use = 1'b0;
        idle();
        check_res("mult_ignore_second");

        mt(HILO_mthi, 32'hDEAD_BEEF, 1'b1);
        check_reg("mthi", 32'hDEAD_BEEF, 32'd12);
        mt(HILO_mthi, 32'h1234_5678, 1'b0);
        mt(HILO_mtlo, 32'h1234_5678, 1'b0);
        check_reg("mt_invalid", 32'hDEAD_BEEF, 32'd12);
        mt(HILO_mtlo, 32'hCAFE_F00D, 1'b1);
        check_reg("mtlo", 32'hDEAD_BEEF, 32'hCAFE_F00D);

        @(negedge clk);
        e_valid   = 1'b1;
        hilo_type = HILO_none;
        #1;
        chk("none_out", hilo_out, 32'd0);
        chk("none_start", 32'(start), 32'd0);
        hilo_type = 4'd9;
        #1;
        chk("type9_out", hilo_out, 32'd0);
        e_valid   = 1'b0;
        hilo_type = HILO_mult;
        rs_val    = 32'd5;
        rt_val    = 32'd5;
        #1;
        chk("bubble_no_start", 32'(start), 32'd0);
        @(negedge clk);
        chk("bubble_no_busy", 32'(busy), 32'd0);
        idle();

        // Reset on the 4th busy cycle of a div must discard its result.
        @(negedge clk);
        e_valid   = 1'b1;
        hilo_type = HILO_div;
        rs_val    = 32'd100;
        rt_val    = 32'd7;
        #1;
        chk("rst_div_start", 32'(start), 32'd1);
        @(negedge clk);
        idle();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst_div_busy4", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        check_reg("rst_hilo", 32'd0, 32'd0);
        repeat (12) @(negedge clk);
        chk("rst_no_commit_busy", 32'(busy), 32'd0);
        check_reg("rst_no_commit", 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
